seg_pixel_fetch: RTL

SEG_PIXEL_FETCH -- requirements
Module: seg_pixel_fetch

---
 rtl/seg_pixel_fetch.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/seg_pixel_fetch.sv
// Pixel fetcher: reads num_pixels words from image memory through a credit-limited
// prefetch FIFO and presents them as a valid/ready pixel stream with a last marker.
module seg_pixel_fetch #(
    parameter int ADDR_W     = 32,
    parameter int CH         = 3,
    parameter int CH_W       = 8,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4,
    localparam int PIX_W     = CH * CH_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_pixels,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] img_addr,
    output logic              img_en,
    input  logic [PIX_W-1:0]  img_dout,
    output logic [PIX_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] num_q;
    logic [ADDR_W-1:0] issued;
    logic [ADDR_W-1:0] popped;
    logic [ADDR_W-1:0] last_addr;
    logic [RD_LAT-1:0] rd_vld;
    logic [RD_LAT-1:0] rd_vld_next;
    logic [PIX_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  inflight;
    logic              issue;
    logic              push;
    logic              pop;
    logic              last_accept;
    logic              take_start;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CNT_W'(rd_vld[i]);
        end
    end

    // A read only goes out if its return is guaranteed a FIFO slot.
    assign issue = (state == FETCH) && !clear && (issued != num_q)
                   && ((fifo_count + inflight) < CNT_W'(FIFO_DEPTH));

    assign img_en      = issue;
    assign img_addr    = issue ? (base_q + issued) : last_addr;
    assign push        = rd_vld[RD_LAT-1];
    assign out_valid   = (fifo_count != '0);
    assign out_data    = out_valid ? fifo_mem[rd_ptr] : '0;
    assign out_last    = out_valid && (popped == (num_q - ADDR_W'(1)));
    assign pop         = out_valid && out_ready;
    assign last_accept = pop && out_last;
    assign busy        = (state == FETCH) || (state == DRAIN);
    assign done        = (state == DONE);
    assign take_start  = (state == IDLE) && start;

    always_comb begin
        rd_vld_next    = rd_vld << 1;
        rd_vld_next[0] = issue;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (num_pixels == '0) ? DONE : FETCH;
            FETCH:   if (issued == num_q) state_next = DRAIN;
            DRAIN:   if ((inflight == '0) && last_accept) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clear) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            base_q     <= '0;
            num_q      <= '0;
            issued     <= '0;
            popped     <= '0;
            last_addr  <= '0;
            rd_vld     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            state <= state_next;
            if (issue) last_addr <= img_addr;
            // Abort discards everything in flight, including reads still returning.
            if (clear) begin
                issued     <= '0;
                popped     <= '0;
                rd_vld     <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (take_start) begin
                    base_q <= base_addr;
                    num_q  <= num_pixels;
                    issued <= '0;
                    popped <= '0;
                end else begin
                    if (issue) issued <= issued + ADDR_W'(1);
                    if (pop)   popped <= popped + ADDR_W'(1);
                end
                rd_vld <= rd_vld_next;
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                    2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                    default: fifo_count <= fifo_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) fifo_mem[wr_ptr] <= img_dout;
    end

endmodule
